decode_queue: RTL and testbench

Buffered, parametrised successor to the single-cycle MIPS instruction decoder. It accepts 32-bit instruction words over a valid/ready handshake and stores them in a DEPTH-entry FIFO. The head entry is presented fully decoded (fields, extended immediate, instruction class) over a second valid/ready handshake. It sits between fetch and the register-file/ALU stage, decoupling fetch stalls from execute stalls and supporting a branch flush.

---
 rtl/decode_queue_pkg.sv | 11 +
 rtl/decode_queue_instr_field_decode.sv | 28 ++
 rtl/decode_queue.sv | 65 ++++++
 tb/tb_decode_queue.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// mips_defs: shared MIPS opcode constants and instruction class encodings
package mips_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  typedef enum logic [1:0] {CLASS_R = 2'd0, CLASS_I = 2'd1, CLASS_J = 2'd2} iclass_e;
endpackage

// File: rtl/decode_queue_instr_field_decode.sv
// instr_field_decode: combinational split of a MIPS word into fields, extended immediate and class
module instr_field_decode
  import mips_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic [XLEN-1:0] imm_ext,
  output logic [25:0]     addr,
  output logic [1:0]      iclass
);
  always_comb begin
    {opcode, rs, rt, rd, shamt, funct} = instr;
    imm = instr[15:0];
    addr = instr[25:0];
    iclass = opcode == OP_RTYPE ? CLASS_R :
             (opcode == OP_J || opcode == OP_JAL) ? CLASS_J : CLASS_I;
    imm_ext = (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) ? XLEN'(imm) :
              opcode == OP_LUI ? XLEN'({imm, 16'h0000}) : XLEN'($signed(imm));
  end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO presenting the head entry fully decoded
module decode_queue
  import mips_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [15:0]                imm,
  output logic [XLEN-1:0]            imm_ext,
  output logic [25:0]                addr,
  output logic [1:0]                 iclass,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [31:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  logic [31:0] head;
  always_comb begin
    in_ready = count_q < CW'(DEPTH);
    out_valid = count_q != '0;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    count = count_q;
    // a zero word decodes to all-zero fields, so gating the word gates every output
    head = out_valid ? mem_q[rd_ptr_q] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_instr;
  end
  instr_field_decode #(.XLEN(XLEN)) u_dec (
    .instr(head), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .imm_ext(imm_ext), .addr(addr), .iclass(iclass)
  );
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: queue-model scoreboard plus directed literal checks for decode_queue
module tb_decode_queue;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  logic in_ready, out_valid, in_ready64, out_valid64;
  logic [5:0] opcode, funct, opcode64, funct64;
  logic [4:0] rs, rt, rd, shamt, rs64, rt64, rd64, shamt64;
  logic [15:0] imm, imm64;
  logic [31:0] imm_ext;
  logic [63:0] imm_ext64;
  logic [25:0] addr, addr64;
  logic [1:0] iclass, iclass64;
  logic [2:0] count, count64;
  int n = 0, fails = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .imm_ext(imm_ext),
    .addr(addr), .iclass(iclass), .count(count));

  decode_queue #(.DEPTH(4), .XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready), .opcode(opcode64),
    .rs(rs64), .rt(rt64), .rd(rd64), .shamt(shamt64), .funct(funct64), .imm(imm64),
    .imm_ext(imm_ext64), .addr(addr64), .iclass(iclass64), .count(count64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mext(input logic [31:0] w, input int xl);
    int op = int'(w >> 26);
    logic [63:0] v = 64'(w & 32'hFFFF);
    if (op >= 12 && op <= 14) return v;
    if (op == 15) return v << 16;
    if (v >= 64'd32768) v = v + 64'hFFFF_FFFF_FFFF_0000;
    return xl == 32 ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  function automatic logic [1:0] mcls(input logic [31:0] w);
    int op = int'(w >> 26);
    return op == 0 ? 2'd0 : (op == 2 || op == 3) ? 2'd2 : 2'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) q.delete();
    else begin
      bit p, o;
      p = in_valid && q.size() < 4;
      o = out_ready && q.size() > 0;
      if (o) void'(q.pop_front());
      if (p) q.push_back(in_instr);
    end
  end

  always @(negedge clk) begin
    logic [31:0] w;
    w = q.size() != 0 ? q[0] : 32'h0;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 4);
    chk("count", count, q.size());
    chk("opcode", opcode, (w >> 26) & 32'h3F);
    chk("rs", rs, (w >> 21) & 32'h1F);
    chk("rt", rt, (w >> 16) & 32'h1F);
    chk("rd", rd, (w >> 11) & 32'h1F);
    chk("shamt", shamt, (w >> 6) & 32'h1F);
    chk("funct", funct, w & 32'h3F);
    chk("imm", imm, w & 32'hFFFF);
    chk("addr", addr, w & 32'h3FF_FFFF);
    chk("iclass", iclass, mcls(w));
    chk("imm_ext", imm_ext, mext(w, 32));
    chk("imm_ext64", imm_ext64, mext(w, 64));
    chk("count64", count64, q.size());
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f = 0);
    in_valid = v; in_instr = w; out_ready = r; flush = f;
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    #10 rst_n = 1;
    drive(1, 32'h02A7E820, 1);
    chk("r_valid", out_valid, 1);
    chk("r_opcode", opcode, 0);
    chk("r_rs", rs, 21);
    chk("r_rt", rt, 7);
    chk("r_rd", rd, 29);
    chk("r_funct", funct, 6'h20);
    chk("r_iclass", iclass, 0);
    drive(0, 0, 1);
    chk("r_count", count, 0);
    drive(1, 32'h22A7EB23, 0);
    drive(1, 32'h36A7EB23, 0);
    drive(1, 32'h3C01EB23, 0);
    chk("addi_ext", imm_ext, 32'hFFFFEB23);
    chk("addi_ext64", imm_ext64, 64'hFFFFFFFFFFFFEB23);
    chk("addi_cls", iclass, 1);
    drive(0, 0, 1);
    chk("ori_ext", imm_ext, 32'h0000EB23);
    chk("ori_ext64", imm_ext64, 64'h000000000000EB23);
    chk("ori_cls", iclass, 1);
    drive(0, 0, 1);
    chk("lui_ext", imm_ext, 32'hEB230000);
    chk("lui_ext64", imm_ext64, 64'h00000000EB230000);
    chk("lui_cls", iclass, 1);
    drive(0, 0, 1);
    drive(1, 32'h0AA7EB23, 1);
    chk("j_opcode", opcode, 2);
    chk("j_addr", addr, 26'h2A7EB23);
    chk("j_cls", iclass, 2);
    drive(0, 0, 1);
    drive(1, 32'h2148FFFF, 0);
    drive(1, 32'h00A63020, 0);
    drive(1, 32'h0C000010, 0);
    drive(1, 32'h3508ABCD, 0);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("stall_ext", imm_ext, 32'hFFFFFFFF);
    drive(1, 32'hDEADBEEF, 0);
    chk("full_count2", count, 4);
    chk("stall_opcode", opcode, 8);
    chk("stall_ext2", imm_ext, 32'hFFFFFFFF);
    drive(0, 0, 1);
    chk("pop_count3", count, 3);
    chk("pop_funct", funct, 6'h20);
    drive(0, 0, 1);
    chk("pop_count2", count, 2);
    chk("pop_cls", iclass, 2);
    drive(0, 0, 1);
    chk("pop_count1", count, 1);
    chk("pop_ext", imm_ext, 32'h0000ABCD);
    drive(0, 0, 1);
    chk("pop_count0", count, 0);
    chk("pop_valid", out_valid, 0);
    drive(1, 32'h8C220004, 0);
    drive(1, 32'hAC220008, 0);
    drive(1, 32'h10220003, 1);
    chk("sp_count1", count, 2);
    chk("sp_op1", opcode, 6'h2B);
    drive(1, 32'h3C1F1234, 1);
    chk("sp_count2", count, 2);
    chk("sp_op2", opcode, 4);
    drive(1, 32'h24420001, 1);
    chk("sp_count3", count, 2);
    chk("sp_op3", opcode, 6'h0F);
    drive(0, 0, 1);
    chk("sp_op4", opcode, 9);
    drive(0, 0, 1);
    drive(1, 32'h11111111, 0);
    drive(1, 32'h22222222, 0);
    drive(1, 32'h33333333, 0);
    drive(1, 32'hCAFEF00D, 0, 1);
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    drive(0, 0, 0);
    chk("fl_absent", count, 0);
    drive(1, 32'h2148FFFF, 0);
    drive(1, 32'h0AA7EB23, 0);
    chk("refill_count", count, 2);
    #2 rst_n = 0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_opcode", opcode, 0);
    chk("ar_rs", rs, 0);
    chk("ar_imm", imm, 0);
    chk("ar_ext", imm_ext, 0);
    chk("ar_ext64", imm_ext64, 0);
    chk("ar_in_ready", in_ready, 1);
    #3 rst_n = 1;
    drive(1, 32'h36A7EB23, 0);
    chk("post_ext", imm_ext, 32'h0000EB23);
    drive(0, 0, 1);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
